// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must be able to hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/ready/done conversion port for bin_to_bcd_seq.
// Handshake: start is honoured only on an edge where ready=1 (bin captured on
// that edge); done pulses one cycle when bcd carries a freshly completed result.
interface bin_to_bcd_seq_if #(
    parameter int N      = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [N-1:0]          bin;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input ready, input done, input bcd);
    modport slave  (input start, input bin, output ready, output done, output bcd);
endinterface

// File: rtl/bin_to_bcd_seq_adj3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3.
module bcd_digit_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// bcd only changes on completion, so displays never see partial values.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int N      = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus,
    output state_t            dbg_state
);
    localparam int CW = cnt_width(N);
    localparam int W  = 4 * DIGITS;

    state_t          state_q, state_n;
    logic [N-1:0]    bin_sr, bin_sr_n;
    logic [W-1:0]    scratch, scratch_n;
    logic [W-1:0]    adj;
    logic [W-1:0]    bcd_q, bcd_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            done_q, done_n;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .digit    (scratch[4*d +: 4]),
            .adjusted (adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            bin_sr  <= bin_sr_n;
            scratch <= scratch_n;
            cnt     <= cnt_n;
            bcd_q   <= bcd_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        bin_sr_n  = bin_sr;
        scratch_n = scratch;
        cnt_n     = cnt;
        bcd_n     = bcd_q;
        done_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_sr_n  = bus.bin;
                    scratch_n = '0;
                    cnt_n     = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                // Adjust first, then shift the binary MSB into the scratch LSB.
                scratch_n = {adj[W-2:0], bin_sr[N-1]};
                bin_sr_n  = {bin_sr[N-2:0], 1'b0};
                cnt_n     = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    bcd_n   = scratch_n;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign dbg_state = state_q;

endmodule
